cnt_timer_ctrl: RTL and testbench

- Countdown-timer controller (kitchen-timer style) built around an internal 1 Hz prescaler with the same tick semantics as the existing 1-second counter.
- Sequences set/run/pause/alarm of an mm:ss BCD time value from one-cycle command pulses.
- Drives 7-seg digit data, a colon blink signal and the alarm indication for the board top level.

---
 rtl/cnt_timer_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_cnt_timer_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_timer_ctrl.sv
// Countdown timer controller: mm:ss BCD value, set/run/pause/alarm sequencing
// from one-cycle command pulses, with an internal 1 Hz prescaler that only
// advances while the timer is running or alarming.
module cnt_timer_ctrl #(
  parameter int FREQ      = 50_000_000,
  parameter int ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clr,
  input  logic       inc_min,
  input  logic       inc_sec,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic       run,
  output logic       alarm,
  output logic       done,
  output logic       blink
);

  localparam int CW = $clog2(FREQ);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(FREQ - 1);
  localparam logic [CW-1:0] CNT_Q1   = CW'(FREQ / 4);
  localparam logic [CW-1:0] CNT_HALF = CW'(FREQ / 2);
  localparam logic [CW-1:0] CNT_Q3   = CW'((3 * FREQ) / 4);
  localparam logic [7:0]    AL_INIT  = 8'(ALARM_SEC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_al_cnt;
  logic [15:0]   r_time;    // {min10, min1, sec10, sec1}
  logic          r_run;
  logic          r_alarm;
  logic          r_done;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [7:0]    w_al_nxt;
  logic [15:0]   w_time_nxt;
  logic [15:0]   w_dec;
  logic          w_done_nxt;
  logic          w_tick;
  logic          w_blink;

  // Decrement a non-zero mm:ss BCD value, borrowing digit by digit.
  function automatic logic [15:0] bcd_dec_time(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) begin
        r[7:4] = t[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) begin
          r[11:8] = t[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = t[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Two-digit BCD increment that wraps to 00 after {tens_max, 9}.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] tens_max);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (v[7:4] == tens_max) begin
        r[7:4] = 4'd0;
      end else begin
        r[7:4] = v[7:4] + 4'd1;
      end
    end else begin
      r[7:4] = v[7:4];
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  assign w_tick = (r_cnt == CNT_MAX);
  assign w_dec  = bcd_dec_time(r_time);

  // Next-state, prescaler, alarm counter and time update with command priority
  // clr > stop > start > inc_min > inc_sec.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_al_nxt    = r_al_cnt;
    w_time_nxt  = r_time;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = CNT_ZERO;
        if (clr) begin
          w_time_nxt = 16'h0000;
        end else if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (start) begin
          if (r_time != 16'h0000) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (inc_min) begin
          w_time_nxt[15:8] = bcd_inc(r_time[15:8], 4'd9);
        end else if (inc_sec) begin
          w_time_nxt[7:0] = bcd_inc(r_time[7:0], 4'd5);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (clr) begin
          w_state_nxt = S_IDLE;
          w_time_nxt  = 16'h0000;
          w_cnt_nxt   = CNT_ZERO;
        end else if (w_tick) begin
          // A decrement to zero wins over a concurrent stop.
          w_time_nxt = w_dec;
          w_cnt_nxt  = CNT_ZERO;
          if (w_dec == 16'h0000) begin
            w_state_nxt = S_ALARM;
            w_done_nxt  = 1'b1;
            w_al_nxt    = AL_INIT;
          end else if (stop) begin
            w_state_nxt = S_PAUSE;
          end else begin
            w_state_nxt = S_RUN;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
          if (stop) begin
            w_state_nxt = S_PAUSE;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_PAUSE: begin
        // Prescaler is held so a resume continues the interrupted second.
        if (clr) begin
          w_state_nxt = S_IDLE;
          w_time_nxt  = 16'h0000;
          w_cnt_nxt   = CNT_ZERO;
        end else if (stop) begin
          w_state_nxt = S_PAUSE;
        end else if (start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_PAUSE;
        end
      end
      S_ALARM: begin
        if (clr || stop || start) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
          w_al_nxt    = 8'd0;
        end else if (w_tick) begin
          w_cnt_nxt = CNT_ZERO;
          if (r_al_cnt <= 8'd1) begin
            w_state_nxt = S_IDLE;
            w_al_nxt    = 8'd0;
          end else begin
            w_al_nxt = r_al_cnt - 8'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_time_nxt  = 16'h0000;
        w_cnt_nxt   = CNT_ZERO;
        w_al_nxt    = 8'd0;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= CNT_ZERO;
      r_al_cnt <= 8'd0;
      r_time   <= 16'h0000;
      r_run    <= 1'b0;
      r_alarm  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_al_cnt <= w_al_nxt;
      r_time   <= w_time_nxt;
      r_run    <= (w_state_nxt == S_RUN);
      r_alarm  <= (w_state_nxt == S_ALARM);
      r_done   <= w_done_nxt;
    end
  end

  // Colon/alarm blink: steady when idle or paused, 1 Hz in RUN, 2 Hz in ALARM.
  always_comb begin
    w_blink = 1'b1;
    case (r_state)
      S_IDLE:  w_blink = 1'b1;
      S_PAUSE: w_blink = 1'b1;
      S_RUN:   w_blink = (r_cnt < CNT_HALF);
      S_ALARM: w_blink = (r_cnt < CNT_Q1) || ((r_cnt >= CNT_HALF) && (r_cnt < CNT_Q3));
      default: w_blink = 1'b1;
    endcase
  end

  assign min10 = r_time[15:12];
  assign min1  = r_time[11:8];
  assign sec10 = r_time[7:4];
  assign sec1  = r_time[3:0];
  assign run   = r_run;
  assign alarm = r_alarm;
  assign done  = r_done;
  assign blink = w_blink;

endmodule

// File: tb/tb_cnt_timer_ctrl.sv
// Self-checking bench for cnt_timer_ctrl: directed scenarios with hand-derived
// expectations plus a randomized command stream checked against a
// seconds-arithmetic reference model.
module tb_cnt_timer_ctrl;

  localparam int F  = 8;
  localparam int AS = 2;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_ALARM = 3;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0, stop = 1'b0, clr = 1'b0, inc_min = 1'b0, inc_sec = 1'b0;
  logic [3:0] min10, min1, sec10, sec1;
  logic run, alarm, done, blink;

  // observed vector: {mm:ss BCD, run, alarm, done, blink}
  logic [19:0] obs;
  logic [19:0] exp;
  assign obs = {min10, min1, sec10, sec1, run, alarm, done, blink};

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state: minutes and seconds as plain integers
  int m_mode, m_min, m_sec, m_ph, m_al;
  bit m_done;

  cnt_timer_ctrl #(.FREQ(F), .ALARM_SEC(AS)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .stop(stop), .clr(clr),
    .inc_min(inc_min), .inc_sec(inc_sec),
    .min10(min10), .min1(min1), .sec10(sec10), .sec1(sec1),
    .run(run), .alarm(alarm), .done(done), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_mode = M_IDLE; m_min = 0; m_sec = 0; m_ph = 0; m_al = 0; m_done = 1'b0;
  endtask

  // One clock edge of the reference model, commands sampled at that edge.
  task automatic m_step(input bit st, input bit sp, input bit cl, input bit im, input bit is);
    int  t;
    bit  tick;
    t = -1;
    m_done = 1'b0;
    tick = ((m_mode == M_RUN) || (m_mode == M_ALARM)) && (m_ph == F - 1);
    case (m_mode)
      M_IDLE: begin
        m_ph = 0;
        if (cl) begin m_min = 0; m_sec = 0; end
        else if (sp) begin end
        else if (st) begin if (m_min * 60 + m_sec != 0) m_mode = M_RUN; end
        else if (im) m_min = (m_min + 1) % 100;
        else if (is) m_sec = (m_sec + 1) % 60;
      end
      M_RUN: begin
        if (cl) begin
          m_mode = M_IDLE; m_min = 0; m_sec = 0; m_ph = 0;
        end else begin
          m_ph = tick ? 0 : m_ph + 1;
          if (tick) begin
            t = m_min * 60 + m_sec - 1;
            m_min = t / 60; m_sec = t % 60;
          end
          if (tick && t == 0) begin
            m_mode = M_ALARM; m_done = 1'b1; m_al = AS; m_ph = 0;
          end else if (sp) m_mode = M_PAUSE;
        end
      end
      M_PAUSE: begin
        if (cl) begin m_mode = M_IDLE; m_min = 0; m_sec = 0; m_ph = 0; end
        else if (sp) begin end
        else if (st) m_mode = M_RUN;
      end
      default: begin
        if (cl || sp || st) begin
          m_mode = M_IDLE; m_ph = 0;
        end else begin
          m_ph = tick ? 0 : m_ph + 1;
          if (tick) begin
            m_al = m_al - 1;
            if (m_al == 0) begin m_mode = M_IDLE; m_ph = 0; end
          end
        end
      end
    endcase
  endtask

  function automatic logic [19:0] m_expect();
    bit b;
    if (m_mode == M_RUN) b = (m_ph < F / 2);
    else if (m_mode == M_ALARM) b = (m_ph < F / 4) || (m_ph >= F / 2 && m_ph < 3 * F / 4);
    else b = 1'b1;
    return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
            m_mode == M_RUN, m_mode == M_ALARM, m_done, b};
  endfunction

  // Drive one cycle of command pulses (order: start, stop, clr, inc_min, inc_sec).
  task automatic pulse(input bit st, input bit sp, input bit cl, input bit im, input bit is);
    @(negedge clk);
    start = st; stop = sp; clr = cl; inc_min = im; inc_sec = is;
    @(posedge clk);
    m_step(st, sp, cl, im, is);
    #1;
    start = 1'b0; stop = 1'b0; clr = 1'b0; inc_min = 1'b0; inc_sec = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    exp = {16'h0000, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL reset_state: got %h want %h", obs, exp); else n_pass++;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_countdown();
    repeat (3) pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp = {16'h0003, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL cd_set: got %h want %h", obs, exp); else n_pass++;
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp = {16'h0003, 4'b1001}; n_checks++;
    if (obs !== exp) $display("FAIL cd_start: got %h want %h", obs, exp); else n_pass++;
    idle(7);
    exp = {16'h0003, 4'b1000}; n_checks++;
    if (obs !== exp) $display("FAIL cd_before_tick: got %h want %h", obs, exp); else n_pass++;
    idle(1);
    exp = {16'h0002, 4'b1001}; n_checks++;
    if (obs !== exp) $display("FAIL cd_8: got %h want %h", obs, exp); else n_pass++;
    idle(8);
    exp = {16'h0001, 4'b1001}; n_checks++;
    if (obs !== exp) $display("FAIL cd_16: got %h want %h", obs, exp); else n_pass++;
    idle(8);
    exp = {16'h0000, 4'b0111}; n_checks++;
    if (obs !== exp) $display("FAIL cd_24_alarm: got %h want %h", obs, exp); else n_pass++;
    idle(1);
    exp = {16'h0000, 4'b0101}; n_checks++;
    if (obs !== exp) $display("FAIL cd_done_once: got %h want %h", obs, exp); else n_pass++;
    idle(1);
    exp = {16'h0000, 4'b0100}; n_checks++;
    if (obs !== exp) $display("FAIL cd_alarm_blink: got %h want %h", obs, exp); else n_pass++;
    idle(13);
    exp = {16'h0000, 4'b0100}; n_checks++;
    if (obs !== exp) $display("FAIL cd_alarm_hold: got %h want %h", obs, exp); else n_pass++;
    idle(1);
    exp = {16'h0000, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL cd_alarm_end: got %h want %h", obs, exp); else n_pass++;
  endtask

  task automatic test_borrow();
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(8);
    exp = {16'h0059, 4'b1001}; n_checks++;
    if (obs !== exp) $display("FAIL borrow_min: got %h want %h", obs, exp); else n_pass++;
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp = {16'h1000, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL set_10min: got %h want %h", obs, exp); else n_pass++;
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(8);
    exp = {16'h0959, 4'b1001}; n_checks++;
    if (obs !== exp) $display("FAIL borrow_double: got %h want %h", obs, exp); else n_pass++;
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp = {16'h0000, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL run_clr: got %h want %h", obs, exp); else n_pass++;
  endtask

  task automatic test_pause();
    repeat (5) pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      exp = {16'h0005, 4'b0001}; n_checks++;
      if (obs !== exp) $display("FAIL pause_hold[%0d]: got %h want %h", i, obs, exp); else n_pass++;
      pulse(1'b0, 1'b1, 1'b0, i[0], ~i[0]);
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    exp = {16'h0005, 4'b1000}; n_checks++;
    if (obs !== exp) $display("FAIL resume_2: got %h want %h", obs, exp); else n_pass++;
    idle(1);
    exp = {16'h0004, 4'b1001}; n_checks++;
    if (obs !== exp) $display("FAIL resume_3: got %h want %h", obs, exp); else n_pass++;
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (59) pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp = {16'h0159, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL sec_59: got %h want %h", obs, exp); else n_pass++;
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp = {16'h0100, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL sec_wrap: got %h want %h", obs, exp); else n_pass++;
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (99) pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp = {16'h9900, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL min_99: got %h want %h", obs, exp); else n_pass++;
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp = {16'h0000, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL min_wrap: got %h want %h", obs, exp); else n_pass++;
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp = {16'h0000, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL zero_start: got %h want %h", obs, exp); else n_pass++;
  endtask

  task automatic test_simultaneous();
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(7);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp = {16'h0000, 4'b0111}; n_checks++;
    if (obs !== exp) $display("FAIL tick_stop_zero: got %h want %h", obs, exp); else n_pass++;
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp = {16'h0000, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL alarm_stop: got %h want %h", obs, exp); else n_pass++;
    repeat (3) pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(7);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp = {16'h0002, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL tick_stop_pause: got %h want %h", obs, exp); else n_pass++;
    pulse(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    exp = {16'h0000, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL pause_clr_start: got %h want %h", obs, exp); else n_pass++;
    repeat (2) pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(7);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp = {16'h0000, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL tick_clr: got %h want %h", obs, exp); else n_pass++;
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    exp = {16'h0100, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL prio_min_sec: got %h want %h", obs, exp); else n_pass++;
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp = {16'h0100, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL prio_stop_start: got %h want %h", obs, exp); else n_pass++;
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(8);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp = {16'h0000, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL alarm_start_no_rearm: got %h want %h", obs, exp); else n_pass++;
  endtask

  task automatic test_async_reset();
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (30) pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    exp = {16'h0130, 4'b1001}; n_checks++;
    if (obs !== exp) $display("FAIL pre_reset_run: got %h want %h", obs, exp); else n_pass++;
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    m_reset();
    #1;
    exp = {16'h0000, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL async_reset: got %h want %h", obs, exp); else n_pass++;
    @(negedge clk);
    n_rst = 1'b1;
    idle(1);
    exp = {16'h0000, 4'b0001}; n_checks++;
    if (obs !== exp) $display("FAIL post_reset: got %h want %h", obs, exp); else n_pass++;
  endtask

  task automatic test_random();
    bit st, sp, cl, im, is;
    for (int i = 0; i < 2500; i++) begin
      st = ($urandom_range(0, 99) < 6);
      sp = ($urandom_range(0, 99) < 3);
      cl = ($urandom_range(0, 99) < 1);
      im = ($urandom_range(0, 99) < 2);
      is = ($urandom_range(0, 99) < 10);
      pulse(st, sp, cl, im, is);
      exp = m_expect(); n_checks++;
      if (obs !== exp) $display("FAIL random[%0d]: got %h want %h", i, obs, exp); else n_pass++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
